// File: rtl/audio_mixer_seq_if.sv
// Bus bundle for audio_mixer_seq: frame strobe, packed channel inputs and the mixer's PCM/DAC outputs.
// The master drives the strobe and source samples; the slave (the mixer) drives status and audio.
interface audio_mixer_seq_if #(
    parameter int CHANNELS = 8,
    parameter int DW       = 8,
    parameter int GW       = 4,
    parameter int OW       = 12
);
    logic                   strobe;
    logic [CHANNELS*DW-1:0] ch_data;
    logic [CHANNELS*GW-1:0] ch_gain;
    logic [CHANNELS*2-1:0]  ch_pan;
    logic                   busy;
    logic                   valid;
    logic                   overrun;
    logic [1:0]             clip;
    logic [OW-1:0]          left;
    logic [OW-1:0]          right;
    logic [1:0]             audio;

    modport master (
        output strobe, ch_data, ch_gain, ch_pan,
        input  busy, valid, overrun, clip, left, right, audio
    );

    modport slave (
        input  strobe, ch_data, ch_gain, ch_pan,
        output busy, valid, overrun, clip, left, right, audio
    );
endinterface

// File: rtl/audio_mixer_seq.sv
// Time-multiplexed stereo mixer: one multiply-accumulate per channel per frame, saturating PCM
// output and a first-order sigma-delta DAC per side running every clock on the held PCM values.
module audio_mixer_seq #(
    parameter int CHANNELS = 8,
    parameter int DW       = 8,
    parameter int GW       = 4,
    parameter int OW       = 12,
    parameter int SHIFT    = 2
) (
    input logic              clock,
    input logic              reset,
    audio_mixer_seq_if.slave bus
);
    localparam int IW = $clog2(CHANNELS);
    localparam int AW = DW + GW + $clog2(CHANNELS);
    // Compare width leaves at least one bit above OW so the saturation test never truncates.
    localparam int SW = ((AW > OW) ? AW : OW) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Returns {clipped, pcm} for one accumulator after the output shift.
    function automatic logic [OW:0] sat_pcm(input logic [AW-1:0] acc);
        logic [SW-1:0] s;
        logic [SW-1:0] max_v;
        s     = SW'(acc >> SHIFT);
        max_v = {{(SW-OW){1'b0}}, {OW{1'b1}}};
        if (s > max_v) begin
            sat_pcm = {1'b1, {OW{1'b1}}};
        end else begin
            sat_pcm = {1'b0, s[OW-1:0]};
        end
    endfunction

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CHANNELS*DW-1:0] data_q, data_d;
    logic [CHANNELS*GW-1:0] gain_q, gain_d;
    logic [CHANNELS*2-1:0]  pan_q, pan_d;
    logic [AW-1:0]          acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic                   busy_q, busy_d, valid_q, valid_d, overrun_q, overrun_d;
    logic [1:0]             clip_q, clip_d, audio_q, audio_d;
    logic [OW-1:0]          left_q, left_d, right_q, right_d;
    logic [OW-1:0]          int_l_q, int_l_d, int_r_q, int_r_d;

    logic [DW-1:0] sel_data_s;
    logic [GW-1:0] sel_gain_s;
    logic [1:0]    sel_pan_s;
    logic [AW-1:0] prod_s;
    logic [OW:0]   sat_l_s, sat_r_s, sd_l_s, sd_r_s;

    // Next-state logic for the mix FSM, datapath and both sigma-delta integrators.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        gain_d    = gain_q;
        pan_d     = pan_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        clip_d    = clip_q;
        left_d    = left_q;
        right_d   = right_q;

        sel_data_s = data_q[int'(idx_q)*DW +: DW];
        sel_gain_s = gain_q[int'(idx_q)*GW +: GW];
        sel_pan_s  = pan_q[int'(idx_q)*2 +: 2];
        prod_s     = AW'(sel_data_s) * AW'(sel_gain_s);
        sat_l_s    = sat_pcm(acc_l_q);
        sat_r_s    = sat_pcm(acc_r_q);

        case (state_q)
            IDLE: begin
                if (bus.strobe) begin
                    data_d  = bus.ch_data;
                    gain_d  = bus.ch_gain;
                    pan_d   = bus.ch_pan;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    clip_d  = 2'b00;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                overrun_d = bus.strobe;
                acc_l_d   = acc_l_q + (sel_pan_s[0] ? prod_s : {AW{1'b0}});
                acc_r_d   = acc_r_q + (sel_pan_s[1] ? prod_s : {AW{1'b0}});
                idx_d     = idx_q + IW'(1);
                if (idx_q == IW'(CHANNELS - 1)) begin
                    state_d = OUTPUT;
                end else begin
                    state_d = ACCUM;
                end
            end
            OUTPUT: begin
                overrun_d = bus.strobe;
                left_d    = sat_l_s[OW-1:0];
                right_d   = sat_r_s[OW-1:0];
                clip_d    = clip_q | {sat_r_s[OW], sat_l_s[OW]};
                valid_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // The carry out of each integrator is the 1-bit DAC sample.
        sd_l_s     = {1'b0, int_l_q} + {1'b0, left_q};
        sd_r_s     = {1'b0, int_r_q} + {1'b0, right_q};
        int_l_d    = sd_l_s[OW-1:0];
        int_r_d    = sd_r_s[OW-1:0];
        audio_d    = {sd_r_s[OW], sd_l_s[OW]};
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            gain_q    <= '0;
            pan_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            clip_q    <= 2'b00;
            left_q    <= '0;
            right_q   <= '0;
            int_l_q   <= '0;
            int_r_q   <= '0;
            audio_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            gain_q    <= gain_d;
            pan_q     <= pan_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            clip_q    <= clip_d;
            left_q    <= left_d;
            right_q   <= right_d;
            int_l_q   <= int_l_d;
            int_r_q   <= int_r_d;
            audio_q   <= audio_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.valid   = valid_q;
    assign bus.overrun = overrun_q;
    assign bus.clip    = clip_q;
    assign bus.left    = left_q;
    assign bus.right   = right_q;
    assign bus.audio   = audio_q;
endmodule

// File: tb/tb_audio_mixer_seq.sv
// Directed bench for audio_mixer_seq: two 4-channel instances, SHIFT=2 (bus_a) and SHIFT=0 (bus_b).
module tb_audio_mixer_seq;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    audio_mixer_seq_if #(.CHANNELS(4), .DW(8), .GW(4), .OW(12)) bus_a ();
    audio_mixer_seq_if #(.CHANNELS(4), .DW(8), .GW(4), .OW(12)) bus_b ();

    audio_mixer_seq #(.CHANNELS(4), .DW(8), .GW(4), .OW(12), .SHIFT(2)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a)
    );
    audio_mixer_seq #(.CHANNELS(4), .DW(8), .GW(4), .OW(12), .SHIFT(0)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called at a falling edge; returns one falling edge later with strobe released.
    task automatic start_a(input logic [31:0] d, input logic [15:0] g, input logic [7:0] p);
        bus_a.ch_data = d;
        bus_a.ch_gain = g;
        bus_a.ch_pan  = p;
        bus_a.strobe  = 1'b1;
        @(negedge clock);
        bus_a.strobe  = 1'b0;
    endtask

    task automatic start_b(input logic [31:0] d, input logic [15:0] g, input logic [7:0] p);
        bus_b.ch_data = d;
        bus_b.ch_gain = g;
        bus_b.ch_pan  = p;
        bus_b.strobe  = 1'b1;
        @(negedge clock);
        bus_b.strobe  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
        n_cmp++; if (bus_a.valid !== 1'b0 || bus_a.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got valid=%b overrun=%b want 0 0", bus_a.valid, bus_a.overrun); end
        n_cmp++; if (bus_a.left !== 12'd0 || bus_a.right !== 12'd0) begin n_bad++; $display("FAIL reset_pcm: got %0d/%0d want 0/0", bus_a.left, bus_a.right); end
        n_cmp++; if (bus_a.clip !== 2'b00 || bus_a.audio !== 2'b00) begin n_bad++; $display("FAIL reset_clip_audio: got clip=%b audio=%b want 00 00", bus_a.clip, bus_a.audio); end
    endtask

    task automatic test_single_channel;
        start_a(32'h0000_00FF, 16'h000F, 8'h03);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clock);
            n_cmp++; if (bus_a.busy !== (k <= 5)) begin n_bad++; $display("FAIL latency_busy c%0d: got %b want %b", k, bus_a.busy, (k <= 5)); end
            n_cmp++; if (bus_a.valid !== (k == 6)) begin n_bad++; $display("FAIL latency_valid c%0d: got %b want %b", k, bus_a.valid, (k == 6)); end
        end
        n_cmp++; if (bus_a.left !== 12'd956 || bus_a.right !== 12'd956) begin n_bad++; $display("FAIL single_pcm: got %0d/%0d want 956/956", bus_a.left, bus_a.right); end
        n_cmp++; if (bus_a.clip !== 2'b00) begin n_bad++; $display("FAIL single_clip: got %b want 00", bus_a.clip); end
        @(negedge clock);
        n_cmp++; if (bus_a.valid !== 1'b0) begin n_bad++; $display("FAIL valid_width: got %b want 0", bus_a.valid); end
    endtask

    task automatic test_pan;
        start_a({8'h00, 8'h00, 8'h40, 8'h80}, {4'd0, 4'd0, 4'd4, 4'd8}, {2'b00, 2'b00, 2'b10, 2'b01});
        repeat (5) @(negedge clock);
        n_cmp++; if (bus_a.valid !== 1'b1) begin n_bad++; $display("FAIL pan_valid: got %b want 1", bus_a.valid); end
        n_cmp++; if (bus_a.left !== 12'd256) begin n_bad++; $display("FAIL pan_left: got %0d want 256", bus_a.left); end
        n_cmp++; if (bus_a.right !== 12'd64) begin n_bad++; $display("FAIL pan_right: got %0d want 64", bus_a.right); end
        @(negedge clock);
    endtask

    task automatic test_saturate;
        start_b({4{8'hFF}}, {4{4'hF}}, {4{2'b11}});
        repeat (5) @(negedge clock);
        n_cmp++; if (bus_b.valid !== 1'b1) begin n_bad++; $display("FAIL sat_valid: got %b want 1", bus_b.valid); end
        n_cmp++; if (bus_b.left !== 12'd4095 || bus_b.right !== 12'd4095) begin n_bad++; $display("FAIL sat_pcm: got %0d/%0d want 4095/4095", bus_b.left, bus_b.right); end
        n_cmp++; if (bus_b.clip !== 2'b11) begin n_bad++; $display("FAIL sat_clip: got %b want 11", bus_b.clip); end
        @(negedge clock);
        n_cmp++; if (bus_b.clip !== 2'b11) begin n_bad++; $display("FAIL clip_sticky: got %b want 11", bus_b.clip); end
        start_b({4{8'hFF}}, 16'h0000, 8'hFF);
        n_cmp++; if (bus_b.clip !== 2'b00) begin n_bad++; $display("FAIL clip_clear_on_strobe: got %b want 00", bus_b.clip); end
        repeat (5) @(negedge clock);
        n_cmp++; if (bus_b.left !== 12'd0 || bus_b.right !== 12'd0) begin n_bad++; $display("FAIL mute_pcm: got %0d/%0d want 0/0", bus_b.left, bus_b.right); end
        n_cmp++; if (bus_b.clip !== 2'b00) begin n_bad++; $display("FAIL mute_clip: got %b want 00", bus_b.clip); end
        @(negedge clock);
    endtask

    task automatic test_overrun;
        int n_valid;
        start_a(32'h0000_00FF, 16'h000F, 8'h03);
        @(negedge clock);
        bus_a.ch_data = {8'h00, 8'h00, 8'h40, 8'h80};
        bus_a.ch_gain = {4'd0, 4'd0, 4'd4, 4'd8};
        bus_a.ch_pan  = {2'b00, 2'b00, 2'b10, 2'b01};
        bus_a.strobe  = 1'b1;
        @(negedge clock);
        bus_a.strobe  = 1'b0;
        n_cmp++; if (bus_a.overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_pulse: got %b want 1", bus_a.overrun); end
        @(negedge clock);
        n_cmp++; if (bus_a.overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_width: got %b want 0", bus_a.overrun); end
        n_valid = 0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clock);
            if (bus_a.valid === 1'b1) n_valid++;
        end
        n_cmp++; if (n_valid !== 1) begin n_bad++; $display("FAIL overrun_valid_count: got %0d want 1", n_valid); end
        n_cmp++; if (bus_a.left !== 12'd956 || bus_a.right !== 12'd956) begin n_bad++; $display("FAIL snapshot_pcm: got %0d/%0d want 956/956", bus_a.left, bus_a.right); end
    endtask

    task automatic test_back_to_back;
        start_a(32'h0000_00FF, 16'h000F, 8'h03);
        repeat (4) @(negedge clock);
        bus_a.ch_data = {8'h00, 8'h00, 8'h40, 8'h80};
        bus_a.ch_gain = {4'd0, 4'd0, 4'd4, 4'd8};
        bus_a.ch_pan  = {2'b00, 2'b00, 2'b10, 2'b01};
        bus_a.strobe  = 1'b1;
        @(negedge clock);
        n_cmp++; if (bus_a.overrun !== 1'b1 || bus_a.valid !== 1'b1) begin n_bad++; $display("FAIL output_cycle_strobe: got overrun=%b valid=%b want 1 1", bus_a.overrun, bus_a.valid); end
        n_cmp++; if (bus_a.left !== 12'd956) begin n_bad++; $display("FAIL b2b_first: got %0d want 956", bus_a.left); end
        @(negedge clock);
        bus_a.strobe = 1'b0;
        n_cmp++; if (bus_a.busy !== 1'b1 || bus_a.overrun !== 1'b0) begin n_bad++; $display("FAIL valid_cycle_accept: got busy=%b overrun=%b want 1 0", bus_a.busy, bus_a.overrun); end
        repeat (5) @(negedge clock);
        n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.left !== 12'd256 || bus_a.right !== 12'd64) begin n_bad++; $display("FAIL b2b_second: got valid=%b %0d/%0d want 1 256/64", bus_a.valid, bus_a.left, bus_a.right); end
        @(negedge clock);
    endtask

    task automatic test_sigma_delta;
        int ones_l;
        int ones_r;
        start_b({8'h00, 8'h00, 8'h80, 8'h80}, {4'd0, 4'd0, 4'd1, 4'd15}, {2'b00, 2'b00, 2'b01, 2'b01});
        repeat (5) @(negedge clock);
        n_cmp++; if (bus_b.left !== 12'd2048 || bus_b.right !== 12'd0) begin n_bad++; $display("FAIL sd_pcm: got %0d/%0d want 2048/0", bus_b.left, bus_b.right); end
        repeat (4) @(negedge clock);
        ones_l = 0;
        ones_r = 0;
        for (int k = 0; k < 4096; k++) begin
            @(negedge clock);
            ones_l += int'(bus_b.audio[0]);
            ones_r += int'(bus_b.audio[1]);
        end
        n_cmp++; if (ones_l !== 2048) begin n_bad++; $display("FAIL sd_half_ones: got %0d want 2048", ones_l); end
        n_cmp++; if (ones_r !== 0) begin n_bad++; $display("FAIL sd_right_zero: got %0d want 0", ones_r); end
        start_b(32'h0, 16'h0, 8'hFF);
        repeat (5) @(negedge clock);
        n_cmp++; if (bus_b.left !== 12'd0) begin n_bad++; $display("FAIL sd_zero_pcm: got %0d want 0", bus_b.left); end
        repeat (3) @(negedge clock);
        ones_l = 0;
        for (int k = 0; k < 4096; k++) begin
            @(negedge clock);
            ones_l += int'(bus_b.audio[0]);
        end
        n_cmp++; if (ones_l !== 0) begin n_bad++; $display("FAIL sd_zero_ones: got %0d want 0", ones_l); end
    endtask

    task automatic test_reset_mid_frame;
        int n_valid;
        start_a(32'h0000_00FF, 16'h000F, 8'h03);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_cmp++; if (bus_a.busy !== 1'b0 || bus_a.valid !== 1'b0) begin n_bad++; $display("FAIL abort_status: got busy=%b valid=%b want 0 0", bus_a.busy, bus_a.valid); end
        n_cmp++; if (bus_a.left !== 12'd0 || bus_a.right !== 12'd0 || bus_a.audio !== 2'b00) begin n_bad++; $display("FAIL abort_outputs: got %0d/%0d audio=%b want 0/0 00", bus_a.left, bus_a.right, bus_a.audio); end
        n_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus_a.valid === 1'b1) n_valid++;
        end
        n_cmp++; if (n_valid !== 0) begin n_bad++; $display("FAIL abort_no_valid: got %0d want 0", n_valid); end
        start_a({8'h00, 8'h00, 8'h40, 8'h80}, {4'd0, 4'd0, 4'd4, 4'd8}, {2'b00, 2'b00, 2'b10, 2'b01});
        repeat (5) @(negedge clock);
        n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.left !== 12'd256 || bus_a.right !== 12'd64) begin n_bad++; $display("FAIL after_abort: got valid=%b %0d/%0d want 1 256/64", bus_a.valid, bus_a.left, bus_a.right); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus_a.strobe = 1'b0; bus_a.ch_data = '0; bus_a.ch_gain = '0; bus_a.ch_pan = '0;
        bus_b.strobe = 1'b0; bus_b.ch_data = '0; bus_b.ch_gain = '0; bus_b.ch_pan = '0;
        @(negedge clock);
        test_reset();
        test_single_channel();
        test_pan();
        test_saturate();
        test_overrun();
        test_back_to_back();
        test_sigma_delta();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
